parity_checker_rx: RTL and testbench

- Serial receiver and checker for parity-protected words; the receive-side counterpart of the combinational parity generator.
- Accepts a start pulse, DATA_W data bits LSB-first, then one parity bit.
- Reassembles the word, checks parity against the selected even/odd mode and reports a one-cycle done pulse with an error flag.
- Sits between a serial link front end and downstream consumers that need a verified word.

---
 rtl/parity_checker_rx.sv | 116 +++++++++++
 tb/tb_parity_checker_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_checker_rx.sv
`default_nettype none
//============================================================================
// Module      : parity_checker_rx
// Description : Serial parity-word receiver. Takes a start pulse, DATA_W bits
//               LSB-first and one parity bit, then reports word + error flag.
//               Optional error counter: define PARITY_ERR_COUNT_EN.
// Revision    : 1.0 - initial release
//============================================================================
module parity_checker_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              odd_mode,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              done
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int               CNT_W      = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DATA_W - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_data   = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_acc;
    logic              r_mode;
    logic              w_take_start;
    logic              w_take_data;
    logic              w_take_parity;

    assign w_take_start  = (r_state == c_st_idle)   && start;
    assign w_take_data   = (r_state == c_st_data)   && bit_valid;
    assign w_take_parity = (r_state == c_st_parity) && bit_valid;
    assign busy          = (r_state != c_st_idle);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (start) w_state_nxt = c_st_data;
            c_st_data:   if (bit_valid && (r_cnt == c_last_idx)) w_state_nxt = c_st_parity;
            c_st_parity: if (bit_valid) w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_acc      <= 1'b0;
            r_mode     <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_take_start) begin
                r_mode  <= odd_mode;
                r_shift <= '0;
                r_cnt   <= '0;
                r_acc   <= 1'b0;
            end
            if (w_take_data) begin
                // Decoded write keeps the index width independent of DATA_W.
                for (int i = 0; i < DATA_W; i++) begin
                    if (r_cnt == CNT_W'(i)) r_shift[i] <= bit_in;
                end
                r_acc <= r_acc ^ bit_in;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_take_parity) begin
                data_out   <= r_shift;
                parity_err <= r_acc ^ bit_in ^ r_mode;
                done       <= 1'b1;
            end
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (w_take_parity && (r_acc ^ bit_in ^ r_mode) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_checker_rx.sv
`default_nettype none
//============================================================================
// Module      : tb_parity_checker_rx
// Description : Bench for parity_checker_rx: directed frames with literal
//               results, then random traffic against a frame-level model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_parity_checker_rx;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          odd_mode = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          busy;
    logic [DW-1:0] data_out;
    logic          parity_err;
    logic          done;
`ifdef PARITY_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    parity_checker_rx #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .odd_mode   (odd_mode),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .data_out   (data_out),
        .parity_err (parity_err),
        .done       (done)
`ifdef PARITY_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    // Frame-level model: collected bits in a queue, result from a ones count.
    bit            m_active = 1'b0;
    bit            m_mode   = 1'b0;
    bit            m_done   = 1'b0;
    bit            m_err    = 1'b0;
    logic [DW-1:0] m_data   = '0;
    int            m_errs   = 0;
    int            m_ones;
    bit            m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_mode   = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_data   = '0;
            m_errs   = 0;
            m_q.delete();
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_mode   = odd_mode;
                    m_q.delete();
                end
            end else if (bit_valid) begin
                if (m_q.size() < DW) begin
                    m_q.push_back(bit_in);
                end else begin
                    m_data = '0;
                    m_ones = bit_in ? 1 : 0;
                    foreach (m_q[i]) begin
                        if (m_q[i]) begin
                            m_data[i] = 1'b1;
                            m_ones++;
                        end
                    end
                    m_err    = ((m_ones % 2) == 1) != m_mode;
                    m_done   = 1'b1;
                    m_active = 1'b0;
                    if (m_err && m_errs < 255) m_errs++;
                end
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (busy !== m_active || done !== m_done || data_out !== m_data || parity_err !== m_err) begin
            miscompares++;
            $display("FAIL cycle@%0t busy/done/data/err: got %b/%b/%h/%b expected %b/%b/%h/%b",
                     $time, busy, done, data_out, parity_err, m_active, m_done, m_data, m_err);
        end
`ifdef PARITY_ERR_COUNT_EN
        if (err_count !== 8'(m_errs)) begin
            miscompares++;
            $display("FAIL err_count@%0t: got %0d expected %0d", $time, err_count, m_errs);
        end
`endif
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic om, input logic b, input logic v);
        start     = s;
        odd_mode  = om;
        bit_in    = b;
        bit_valid = v;
        @(posedge clk);
        #1;
    endtask

    // odd_mode is inverted after the start cycle to show it is not re-sampled.
    task automatic send_frame(input logic [DW-1:0] w, input logic p, input logic mode,
                              input int stall_at, input int stall_len, input bit glitch);
        drive(1'b1, mode, 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < DW; i++) begin
            if (i == stall_at) repeat (stall_len) drive(1'b0, ~mode, 1'b1, 1'b0);
            drive(glitch && (i == 1), ~mode, w[i], 1'b1);
        end
        drive(1'b0, ~mode, p, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset data", 32'(data_out), 32'd0);
        check("reset err", 32'(parity_err), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(4'b1010, 1'b0, 1'b0, -1, 0, 1'b0);
        check("even ok done", 32'(done), 32'd1);
        check("even ok data", 32'(data_out), 32'hA);
        check("even ok err", 32'(parity_err), 32'd0);
        check("even ok busy", 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("done one cycle", 32'(done), 32'd0);

        send_frame(4'b0001, 1'b0, 1'b0, -1, 0, 1'b0);
        check("even bad err", 32'(parity_err), 32'd1);
        check("even bad data", 32'(data_out), 32'h1);
`ifdef PARITY_ERR_COUNT_EN
        check("err_count first", 32'(err_count), 32'd1);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(4'b1011, 1'b0, 1'b1, -1, 0, 1'b0);
        check("odd ok err", 32'(parity_err), 32'd0);
        check("odd ok data", 32'(data_out), 32'hB);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(4'b1010, 1'b0, 1'b0, 3, 5, 1'b0);
        check("stall data", 32'(data_out), 32'hA);
        check("stall err", 32'(parity_err), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(4'b0110, 1'b0, 1'b0, -1, 0, 1'b1);
        check("glitch data", 32'(data_out), 32'h6);
        check("glitch err", 32'(parity_err), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst data", 32'(data_out), 32'd0);
        check("midrst err", 32'(parity_err), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("midrst done", 32'(done), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(4'b0000, 1'b0, 1'b0, -1, 0, 1'b0);
        check("zero data", 32'(data_out), 32'h0);
        check("zero err", 32'(parity_err), 32'd0);
        check("zero done", 32'(done), 32'd1);

        send_frame(4'b1100, 1'b1, 1'b0, -1, 0, 1'b0);
        check("b2b first err", 32'(parity_err), 32'd1);
        check("b2b first data", 32'(data_out), 32'hC);
`ifdef PARITY_ERR_COUNT_EN
        check("err_count after rst", 32'(err_count), 32'd1);
`endif
        send_frame(4'b0111, 1'b0, 1'b1, -1, 0, 1'b0);
        check("b2b second err", 32'(parity_err), 32'd0);
        check("b2b second data", 32'(data_out), 32'h7);
        check("b2b second done", 32'(done), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PARITY_ERR_COUNT_EN
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int n = 0; n < 260; n++) send_frame(4'b0001, 1'b0, 1'b0, -1, 0, 1'b0);
        check("err_count saturate", 32'(err_count), 32'd255);
`endif

        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
